uart_echo_top: RTL and testbench
================================

Name: uart_echo_top

Overview:
- Top-level UART echo block: receives 8N1 serial frames on RsRx and presents the last good byte on Rx_data.
- Retransmits every good byte on RsTx, same format and baud.
- Contains an input synchronizer, receiver FSM, one-byte holding buffer and transmitter FSM, all on one clock.
- Sits between the board serial pins and user logic; no other ports.

Parameters:
- CLKS_PER_BIT, 32, clock cycles per serial bit (2 ns clock gives a 64 ns bit); must be even and at least 4.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this build.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-low reset; sampled on clk rising edge.
- RsRx  input  1  asynchronous serial input, idle high.
- Rx_data  output  8  last correctly framed received byte.
- RsTx  output  1  serial output, idle high.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Rx_data=8'h00, RsTx=1.
  - Both FSMs go to IDLE; holding buffer empty; synchronizer flops preset to 1.
  - Reset mid-frame aborts RX and TX immediately; no partial byte is retained.
- Input path: RsRx passes through a 2-flop synchronizer before any use (2-cycle latency).
- RX FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a synchronized 0 moves to START; bit counter and cycle counter clear.
  - START: at cycle CLKS_PER_BIT/2-1 re-sample the line.
    - 0: go to DATA with counters reset.
    - 1: glitch; return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), LSB first, into a shift register; after 8 samples go to STOP.
  - STOP: sample at mid-bit.
    - 1: Rx_data is loaded on the next clock edge, a 1-cycle internal rx_done pulses, then go to IDLE.
    - 0: framing error; discard the byte, Rx_data unchanged, no echo; go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronized line is 1, then IDLE.
  - Back-to-back frames are accepted; a start bit may immediately follow the stop mid-sample.
- Echo path:
  - rx_done writes the byte into the holding buffer and marks it full.
  - If the buffer is already full, the new byte overwrites the old one (newest wins).
  - Rx_data still updates in that case.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the buffer is full, on the next edge load the shift register, clear the buffer and enter START.
  - If a buffer write and buffer clear fall on the same edge, the write wins and the buffer stays full.
  - Each state holds for exactly CLKS_PER_BIT cycles.
  - RsTx levels: START=0; DATA = 8 bits LSB first; STOP=1; then IDLE.
  - RsTx is registered and glitch-free.
- Latency from the stop-bit mid-sample edge:
  - Rx_data valid +1 cycle.
  - RsTx falls for the echo start bit +3 cycles when TX is idle.
- Continuous-traffic throughput equals the RX rate, so the buffer never loses bytes at matched baud.

Test Plan:
- Reset: hold rst=0 for 50 cycles with RsRx=1 -> Rx_data=00, RsTx=1 throughout; release -> outputs unchanged while the line idles.
- Single frame 0x01 (bits 0,1,0,0,0,0,0,0,0,1 at 32 clk/bit) -> Rx_data=01 one cycle after the stop mid-sample; RsTx emits 0,1,0,0,0,0,0,0,0,1 at 32 clk/bit starting 3 cycles later.
- Continuous square wave (RsRx toggling every 32 clks after idle) -> each frame decodes as 0x55; Rx_data=55 repeatedly; RsTx echoes a continuous 0x55 stream with no dropped frames.
- Framing error: frame 0x3C with stop bit 0 -> Rx_data keeps its previous value, RsTx stays 1; next valid frame 0xA5 after line high -> Rx_data=A5 and echoed.
- Glitch: RsRx low for 8 cycles then high -> no reception, RX returns to IDLE, Rx_data unchanged.
- Reset mid-frame: assert rst=0 during data bit 4 of an RX frame and during TX data -> Rx_data=00 and RsTx=1 next edge; a full frame 0x7E after release is received and echoed correctly.

Source files
------------

// File: rtl/uart_echo_top.sv
// uart_echo_top: 8N1 UART receiver and echo transmitter sharing one clock.
// A 2-flop synchronizer feeds the RX FSM. Each good byte is shown on
// Rx_data and written to a one-byte holding buffer. The TX FSM drains that
// buffer back out on RsTx at the same baud rate.
module uart_echo_top #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RsRx,
    output logic [DATA_BITS-1:0] Rx_data,
    output logic                 RsTx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Input synchronizer (preset high so reset looks like an idle line)
    logic sync_meta_q;
    logic sync_q;

    // RX FSM and datapath
    rx_state_e            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_done_q, rx_done_d;
    logic [DATA_BITS-1:0] rx_data_q;

    // Holding buffer.
    // Write/clear protocol: rx_done_q acts as a write strobe that is always
    // accepted (newest byte overwrites an unread one); tx_load acts as the
    // read strobe and is only raised while buf_full_q is set. If both land
    // on the same edge, the write wins and the buffer stays full.
    logic [DATA_BITS-1:0] buf_data_q;
    logic                 buf_full_q;

    // TX FSM and datapath
    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_load;

    assign Rx_data = rx_data_q;
    assign RsTx    = tx_line_q;

    // Two-flop synchronizer on the asynchronous serial input
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_meta_q <= 1'b1;
            sync_q      <= 1'b1;
        end else begin
            sync_meta_q <= RsRx;
            sync_q      <= sync_meta_q;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (!rst) rx_state_q <= RX_IDLE;
        else      rx_state_q <= rx_state_d;
    end

    // RX next-state logic
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (!sync_q) rx_state_d = RX_START;
            RX_START: if (rx_cnt_q == CNT_HALF) rx_state_d = sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt_q == CNT_LAST && rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
            RX_STOP:  if (rx_cnt_q == CNT_LAST) rx_state_d = sync_q ? RX_IDLE : RX_WAIT;
            RX_WAIT:  if (sync_q) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // RX outputs: mid-bit counters, LSB-first shift and the done strobe
    always_comb begin
        rx_cnt_d   = rx_cnt_q + CNT_ONE;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) rx_cnt_d = '0;
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = rx_bit_q + BIT_ONE;
                    rx_shift_d = {sync_q, rx_shift_q[DATA_BITS-1:1]};
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d  = '0;
                    rx_done_d = sync_q;
                end
            end
            default: rx_cnt_d = '0;
        endcase
    end

    // RX datapath registers; reset discards any partial byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_done_q  <= rx_done_d;
        end
    end

    // Received-byte register and holding buffer (write beats clear)
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data_q  <= '0;
            buf_data_q <= '0;
            buf_full_q <= 1'b0;
        end else if (rx_done_q) begin
            rx_data_q  <= rx_shift_q;
            buf_data_q <= rx_shift_q;
            buf_full_q <= 1'b1;
        end else if (tx_load) begin
            buf_full_q <= 1'b0;
        end
    end

    // Leaving STOP straight into START keeps TX frame time equal to RX frame time
    assign tx_load = buf_full_q &&
                     ((tx_state_q == TX_IDLE) ||
                      (tx_state_q == TX_STOP && tx_cnt_q == CNT_LAST));

    // TX state register
    always_ff @(posedge clk) begin
        if (!rst) tx_state_q <= TX_IDLE;
        else      tx_state_q <= tx_state_d;
    end

    // TX next-state logic
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE:  if (tx_load) tx_state_d = TX_START;
            TX_START: if (tx_cnt_q == CNT_LAST) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_cnt_q == CNT_LAST && tx_bit_q == BIT_LAST) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_cnt_q == CNT_LAST) tx_state_d = tx_load ? TX_START : TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // TX outputs: bit timing, shift register and the line level for each state
    always_comb begin
        tx_cnt_d   = tx_cnt_q + CNT_ONE;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
            end
            TX_START: begin
                tx_line_d = 1'b0;
                if (tx_cnt_q == CNT_LAST) tx_cnt_d = '0;
            end
            TX_DATA: begin
                tx_line_d = tx_shift_q[0];
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = tx_bit_q + BIT_ONE;
                    tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = '0;
                end
            end
            default: tx_cnt_d = '0;
        endcase
        if (tx_load) tx_shift_d = buf_data_q;
    end

    // TX datapath registers; RsTx comes straight from a flop
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

endmodule

// File: tb/tb_uart_echo_top.sv
// tb_uart_echo_top: directed bench for the UART echo block.
// Inputs are driven and outputs are sampled on the falling clock edge.
// Frame timing, counted in falling edges from the one that drives the start bit:
//   Rx_data holds its old value at edge 307 and shows the new byte at 308.
//   RsTx is still high at 309 and falls at 310. Echo bit k is centred at 326+32k.
`timescale 1ns/1ps
module tb_uart_echo_top;

    localparam int CPB = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       RsRx;
    logic [7:0] Rx_data;
    logic       RsTx;

    int checks   = 0;
    int failures = 0;

    uart_echo_top #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .RsRx    (RsRx),
        .Rx_data (Rx_data),
        .RsTx    (RsTx)
    );

    // clock: 2 ns period
    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // drive one 8N1 frame, one bit per CPB falling edges
    task automatic send_frame(input logic [7:0] val, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, val, 1'b0};
        for (int k = 0; k < 10; k++) begin
            RsRx = frame[k];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Rx_data must switch from prev to val exactly at edge 308
    task automatic expect_rx(input logic [7:0] val, input logic [7:0] prev);
        repeat (307) @(negedge clk);
        check("rx_hold", 32'(Rx_data), 32'(prev));
        @(negedge clk);
        check("rx_load", 32'(Rx_data), 32'(val));
    endtask

    // echo starts exactly at edge 310, then each bit is checked mid-bit
    task automatic expect_echo(input logic [7:0] val);
        logic [9:0] frame;
        frame = {1'b1, val, 1'b0};
        repeat (309) @(negedge clk);
        check("tx_pre", 32'(RsTx), 32'(1'b1));
        @(negedge clk);
        check("tx_fall", 32'(RsTx), 32'(1'b0));
        repeat (16) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx_bit%0d", k), 32'(RsTx), 32'(frame[k]));
            if (k < 9) repeat (CPB) @(negedge clk);
        end
    endtask

    // frame checks started some whole number of frames later
    task automatic later_frame(input int offset, input logic [7:0] val, input logic [7:0] prev);
        repeat (offset) @(negedge clk);
        fork
            expect_rx(val, prev);
            expect_echo(val);
        join
    endtask

    // RsTx must stay high and Rx_data must hold exp_rx for n cycles
    task automatic idle_watch(input int n, input logic [7:0] exp_rx);
        int bad_tx;
        int bad_rx;
        bad_tx = 0;
        bad_rx = 0;
        repeat (n) begin
            @(negedge clk);
            if (RsTx !== 1'b1) bad_tx++;
            if (Rx_data !== exp_rx) bad_rx++;
        end
        check("idle_tx_low_cycles", 32'(bad_tx), 32'd0);
        check("idle_rx_changed_cycles", 32'(bad_rx), 32'd0);
    endtask

    initial begin
        // reset held with an idle line
        rst  = 1'b0;
        RsRx = 1'b1;
        @(negedge clk);
        idle_watch(50, 8'h00);
        rst = 1'b1;
        idle_watch(20, 8'h00);

        // single frame 0x01
        fork
            send_frame(8'h01, 1'b1);
            expect_rx(8'h01, 8'h00);
            expect_echo(8'h01);
        join
        idle_watch(30, 8'h01);

        // square wave: four back-to-back 0x55 frames, continuous echo
        fork
            begin
                for (int f = 0; f < 4; f++) send_frame(8'h55, 1'b1);
            end
            later_frame(0, 8'h55, 8'h01);
            later_frame(320, 8'h55, 8'h55);
            later_frame(640, 8'h55, 8'h55);
            later_frame(960, 8'h55, 8'h55);
        join
        idle_watch(30, 8'h55);

        // framing error on 0x3C: nothing received, nothing echoed
        fork
            send_frame(8'h3C, 1'b0);
            idle_watch(320, 8'h55);
        join
        RsRx = 1'b1;
        idle_watch(40, 8'h55);
        fork
            send_frame(8'hA5, 1'b1);
            expect_rx(8'hA5, 8'h55);
            expect_echo(8'hA5);
        join
        idle_watch(30, 8'hA5);

        // 8-cycle glitch is rejected, next frame still decodes
        RsRx = 1'b0;
        idle_watch(8, 8'hA5);
        RsRx = 1'b1;
        idle_watch(60, 8'hA5);
        fork
            send_frame(8'hC3, 1'b1);
            expect_rx(8'hC3, 8'hA5);
            expect_echo(8'hC3);
        join
        idle_watch(30, 8'hC3);

        // reset while RX is in data bit 4 of 0xFF and TX sends data bit 4 (0) of 0x81
        fork
            begin
                send_frame(8'h81, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            expect_rx(8'h81, 8'hC3);
            begin
                repeat (490) @(negedge clk);
                check("pre_rst_tx_busy", 32'(RsTx), 32'(1'b0));
                check("pre_rst_rx", 32'(Rx_data), 32'h81);
                rst = 1'b0;
                @(negedge clk);
                check("rst_rx_clear", 32'(Rx_data), 32'h00);
                check("rst_tx_high", 32'(RsTx), 32'(1'b1));
                repeat (3) @(negedge clk);
                rst = 1'b1;
            end
        join
        idle_watch(40, 8'h00);
        fork
            send_frame(8'h7E, 1'b1);
            expect_rx(8'h7E, 8'h00);
            expect_echo(8'h7E);
        join
        idle_watch(30, 8'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
